mcu_debug_port: RTL and testbench
=================================

Name: mcu_debug_port

Overview:
- MCU-side stage directly downstream of the debug controller FSM.
- Consumes the controller's one-cycle command strobe and its decoded command lines (pause/resume/reset/register/memory access), and sequences them onto the Otter core's halt, reset, register-file and memory debug ports.
- Returns to the controller: busy, read data, error, and a registered PC.

Parameters:
- TIMEOUT, 1024: max cycles waiting for `mcu_halted` or `mem_ack` before aborting with error (≥2).
- RST_CYCLES, 4: cycles `mcu_rst` is held high per reset command (≥1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- valid  in  1  command strobe from controller, one cycle
- pause  in  1  command: halt core
- resume  in  1  command: release core
- reset  in  1  command: reset core
- reg_rd  in  1  command: read register `addr[4:0]`
- reg_wr  in  1  command: write `d_in` to register `addr[4:0]`
- mem_rd  in  1  command: memory read at `addr`
- mem_wr  in  1  command: memory write of `d_in` at `addr`
- mem_rw_byte  in  1  memory access is byte (1) or word (0)
- addr  in  32  target address / register index
- d_in  in  32  write data
- mcu_busy  out  1  command in progress
- d_rd  out  32  read result
- error  out  1  last command failed
- pc  out  32  registered core PC
- mcu_halt_req  out  1  request core halt at instruction boundary
- mcu_halted  in  1  core is halted
- mcu_rst  out  1  core reset
- mcu_pc  in  32  core PC
- dbg_mem_addr  out  32  memory address
- dbg_mem_din  out  32  memory write data
- dbg_mem_re  out  1  memory read request
- dbg_mem_we  out  1  memory write request
- dbg_mem_size  out  2  0 = byte, 2 = word
- mem_ack  in  1  memory access complete; `mem_rdata` valid on a read
- mem_rdata  in  32  memory read word (aligned)
- dbg_rf_addr  out  5  register index
- dbg_rf_wd  out  32  register write data
- dbg_rf_we  out  1  register write enable
- rf_rdata  in  32  combinational register read data

Behaviour:
- Reset: all outputs 0, `paused` = 0, FSM state = IDLE. An asynchronous assert mid-command aborts immediately and drops every request.
- Command accept:
  - Accepted when `valid` && state == IDLE.
  - `valid` while busy is ignored, with no error.
  - On the accept edge, `addr`, `d_in`, `mem_rw_byte` and the command lines are latched.
  - `mcu_busy` rises the cycle after accept and falls on completion.
  - `d_rd` and `error` update on the completion edge and hold until the next completion.
- Error-on-accept, checked in priority order. Each fails in 1 busy cycle with `error` = 1 and no core-side activity:
  - Number of asserted command lines ≠ 1.
  - Register or memory command while `paused` = 0.
  - Register command with `addr[31:5]` ≠ 0.
  - Word memory access with `addr[1:0]` ≠ 0.
- States: IDLE, HALT_WAIT, RST_HOLD, MEM_WAIT, RF_ACC, DONE.
- pause:
  - If already paused, goes straight to DONE (no error).
  - Otherwise assert `mcu_halt_req` and enter HALT_WAIT.
  - `mcu_halted` seen → `paused` = 1, then DONE.
  - TIMEOUT cycles without `mcu_halted` → drop `mcu_halt_req`, `error` = 1.
- resume: deassert `mcu_halt_req`, clear `paused`, then DONE (no error if not paused).
- reset:
  - RST_HOLD drives `mcu_rst` = 1 for exactly RST_CYCLES cycles, then DONE.
  - `mcu_halt_req` and `paused` are unchanged, so a paused core stays halted after reset.
- Memory commands (MEM_WAIT):
  - `dbg_mem_re`/`dbg_mem_we`, `dbg_mem_addr`, `dbg_mem_size` and `dbg_mem_din` are held until `mem_ack`. Requests drop the cycle after ack.
  - Byte write: `dbg_mem_din` = `d_in[7:0]` replicated ×4.
  - Byte read: `d_rd` = {24'b0, the `mem_rdata` lane selected by `addr[1:0]`} (lane 0 = bits 7:0).
  - Word read: `d_rd` = `mem_rdata`.
  - Timeout → requests drop, `error` = 1, `d_rd` = 0.
- Register commands (RF_ACC), one cycle:
  - Read: `d_rd` = `rf_rdata`, forced to 0 for index 0.
  - Write: `dbg_rf_we` pulses for one cycle. Writes to x0 are suppressed but complete without error.
- DONE: one cycle, then IDLE.
- Total busy latency:
  - pause when already paused, resume, register command: 2 cycles.
  - reset: RST_CYCLES + 1 cycles.
- `pc`: `mcu_pc` registered every cycle, independent of the FSM.
- Timeout counter resets on every state entry and saturates. `mem_ack` arriving on the same edge as the timeout counts as success.

Test Plan:
- pause with `mcu_halted` rising 5 cycles after `mcu_halt_req` → `mcu_halt_req` = 1, busy falls, `error` = 0, `paused` = 1; then resume → `mcu_halt_req` = 0 within 2 cycles.
- Paused; `mem_wr` word, `addr` 0x100, `d_in` 0xDEADBEEF, then `mem_rd` with `mem_rdata` 0xDEADBEEF and ack after 3 cycles → `dbg_mem_we` held until ack, `d_rd` = 0xDEADBEEF. Byte read at 0x103 → `d_rd` = 0x000000DE.
- Paused; `reg_wr` x5 = 0x1234, then `reg_rd` x5 with `rf_rdata` = 0x1234 → `dbg_rf_we` pulses once, `d_rd` = 0x1234. `reg_wr` x0 → `dbg_rf_we` stays 0, `error` = 0.
- Not paused: `mem_rd` → `error` = 1, no `dbg_mem_re`. Paused: word `mem_rd` at 0x102 → `error` = 1. `reg_rd` with `addr` 0x20 → `error` = 1. `valid` with `mem_rd` and `reg_rd` both set → `error` = 1.
- `mcu_halted` never asserts, TIMEOUT = 16 → `error` = 1 after 16 cycles, `mcu_halt_req` = 0. Memory `mem_ack` never asserts → `error` = 1, `d_rd` = 0.
- Paused; reset with RST_CYCLES = 4 → `mcu_rst` high exactly 4 cycles, `mcu_halt_req` stays 1. Assert `reset_n` low mid-MEM_WAIT → all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/mcu_debug_port.sv
// mcu_debug_port
// Sits between the debug controller FSM and the Otter core. A one-cycle
// command strobe is accepted only in IDLE. The command is then sequenced
// onto the core's halt, reset, register-file and memory debug ports, and the
// result (d_rd, error) is published on the completion edge.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   valid + cmd lines   pause/resume/reset/reg_rd/reg_wr/mem_rd/mem_wr strobe
//   mem_rw_byte, addr,  byte/word select, address or register index,
//   d_in                write data
//   mcu_busy, d_rd,     busy, read result, last-command error,
//   error, pc           registered core PC
//   mcu_halt_req/_halted, mcu_rst, mcu_pc      core control
//   dbg_mem_*, mem_ack, mem_rdata              memory debug port
//   dbg_rf_*, rf_rdata                         register-file debug port
//   dbg_state, dbg_paused                      FSM state / paused flag
//
// Handshake: valid is sampled only while the FSM is in IDLE. A valid that
// arrives while busy is dropped without error. Memory requests are level
// signals. They are held, with address, size and data stable, until the
// first cycle mem_ack is high, and they fall on the following cycle.
module mcu_debug_port #(
  parameter int TIMEOUT    = 1024,
  parameter int RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid,
  input  logic        pause,
  input  logic        resume,
  input  logic        reset,
  input  logic        reg_rd,
  input  logic        reg_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        mem_rw_byte,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic        mcu_busy,
  output logic [31:0] d_rd,
  output logic        error,
  output logic [31:0] pc,
  output logic        mcu_halt_req,
  input  logic        mcu_halted,
  output logic        mcu_rst,
  input  logic [31:0] mcu_pc,
  output logic [31:0] dbg_mem_addr,
  output logic [31:0] dbg_mem_din,
  output logic        dbg_mem_re,
  output logic        dbg_mem_we,
  output logic [1:0]  dbg_mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  dbg_rf_addr,
  output logic [31:0] dbg_rf_wd,
  output logic        dbg_rf_we,
  input  logic [31:0] rf_rdata,
  output logic [2:0]  dbg_state,
  output logic        dbg_paused
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HALT_WAIT = 3'd1,
    S_RST_HOLD  = 3'd2,
    S_MEM_WAIT  = 3'd3,
    S_RF_ACC    = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  // Bit positions in the latched command vector
  localparam int C_MWR = 0, C_MRD = 1, C_RWR = 2, C_RRD = 3,
                 C_RST = 4, C_RES = 5, C_PAU = 6;

  localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] T_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] R_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          paused_q, paused_d;
  logic          halt_req_q, halt_req_d;
  logic [6:0]    cmd_q, cmd_d;
  logic          byte_q, byte_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   din_q, din_d;
  logic          res_err_q, res_err_d;
  logic [31:0]   res_data_q, res_data_d;
  logic [31:0]   d_rd_q, d_rd_d;
  logic          error_q, error_d;
  logic [31:0]   pc_q;

  logic [6:0] cmd_in;
  logic       is_reg, is_mem, acc_err;
  logic       mem_act, rf_act;

  assign cmd_in = {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr};
  assign is_reg = reg_rd | reg_wr;
  assign is_mem = mem_rd | mem_wr;

  // Every accept-time check produces the same outcome (error, one busy
  // cycle), so the listed priority order has no visible effect.
  assign acc_err = ($countones(cmd_in) != 1)
                 || ((is_reg || is_mem) && !paused_q)
                 || (is_reg && (addr[31:5] != 27'd0))
                 || (is_mem && !mem_rw_byte && (addr[1:0] != 2'd0));

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    paused_d   = paused_q;
    halt_req_d = halt_req_q;
    cmd_d      = cmd_q;
    byte_d     = byte_q;
    addr_d     = addr_q;
    din_d      = din_q;
    res_err_d  = res_err_q;
    res_data_d = res_data_q;
    d_rd_d     = d_rd_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          cmd_d      = cmd_in;
          byte_d     = mem_rw_byte;
          addr_d     = addr;
          din_d      = d_in;
          res_err_d  = 1'b0;
          res_data_d = 32'd0;
          if (acc_err) begin
            res_err_d = 1'b1;
            state_d   = S_DONE;
          end else if (pause) begin
            // S_RF_ACC doubles as the generic one-cycle action slot, which
            // gives the two-cycle busy time for an already-paused core.
            if (paused_q) begin
              state_d = S_RF_ACC;
            end else begin
              halt_req_d = 1'b1;
              state_d    = S_HALT_WAIT;
            end
          end else if (resume) begin
            halt_req_d = 1'b0;
            paused_d   = 1'b0;
            state_d    = S_RF_ACC;
          end else if (reset) begin
            state_d = S_RST_HOLD;
          end else if (is_reg) begin
            state_d = S_RF_ACC;
          end else begin
            state_d = S_MEM_WAIT;
          end
        end
      end
      S_HALT_WAIT: begin
        if (mcu_halted) begin
          paused_d = 1'b1;
          state_d  = S_DONE;
        end else if (cnt_q == T_LAST) begin
          halt_req_d = 1'b0;
          res_err_d  = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_RST_HOLD: begin
        if (cnt_q == R_LAST) state_d = S_DONE;
      end
      S_MEM_WAIT: begin
        // An ack on the timeout cycle wins over the timeout.
        if (mem_ack) begin
          if (cmd_q[C_MRD]) begin
            res_data_d = byte_q ? {24'd0, mem_rdata[{addr_q[1:0], 3'b000} +: 8]}
                                : mem_rdata;
          end
          state_d = S_DONE;
        end else if (cnt_q == T_LAST) begin
          res_err_d  = 1'b1;
          res_data_d = 32'd0;
          state_d    = S_DONE;
        end
      end
      S_RF_ACC: begin
        if (cmd_q[C_RRD] && (addr_q[4:0] != 5'd0)) res_data_d = rf_rdata;
        state_d = S_DONE;
      end
      S_DONE: begin
        d_rd_d  = res_data_q;
        error_d = res_err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      paused_q   <= 1'b0;
      halt_req_q <= 1'b0;
      cmd_q      <= '0;
      byte_q     <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      res_err_q  <= 1'b0;
      res_data_q <= '0;
      d_rd_q     <= '0;
      error_q    <= 1'b0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      paused_q   <= paused_d;
      halt_req_q <= halt_req_d;
      cmd_q      <= cmd_d;
      byte_q     <= byte_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      res_err_q  <= res_err_d;
      res_data_q <= res_data_d;
      d_rd_q     <= d_rd_d;
      error_q    <= error_d;
      pc_q       <= mcu_pc;
    end
  end

  // Core-side strobes decode from the registered state, so an asynchronous
  // reset drops every request at once.
  assign mem_act = (state_q == S_MEM_WAIT);
  assign rf_act  = (state_q == S_RF_ACC) && (cmd_q[C_RRD] || cmd_q[C_RWR]);

  assign mcu_busy     = (state_q != S_IDLE);
  assign d_rd         = d_rd_q;
  assign error        = error_q;
  assign pc           = pc_q;
  assign mcu_halt_req = halt_req_q;
  assign mcu_rst      = (state_q == S_RST_HOLD);

  assign dbg_mem_re   = mem_act && cmd_q[C_MRD];
  assign dbg_mem_we   = mem_act && cmd_q[C_MWR];
  assign dbg_mem_addr = mem_act ? addr_q : 32'd0;
  assign dbg_mem_size = (mem_act && !byte_q) ? 2'd2 : 2'd0;
  assign dbg_mem_din  = dbg_mem_we ? (byte_q ? {4{din_q[7:0]}} : din_q) : 32'd0;

  assign dbg_rf_addr  = rf_act ? addr_q[4:0] : 5'd0;
  assign dbg_rf_we    = rf_act && cmd_q[C_RWR] && (addr_q[4:0] != 5'd0);
  assign dbg_rf_wd    = dbg_rf_we ? din_q : 32'd0;

  assign dbg_state    = state_q;
  assign dbg_paused   = paused_q;

endmodule

// File: tb/tb_mcu_debug_port.sv
// Directed bench for mcu_debug_port (TIMEOUT=16, RST_CYCLES=4). It includes
// a small core model: halted follows halt_req after 5 edges, memory acks
// after 3 request cycles, and a register file.
module tb_mcu_debug_port;

  localparam logic [6:0] L_PAU = 7'b1000000, L_RES = 7'b0100000,
                         L_RST = 7'b0010000, L_RRD = 7'b0001000,
                         L_RWR = 7'b0000100, L_MRD = 7'b0000010,
                         L_MWR = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid, pause, resume, rst_cmd, reg_rd, reg_wr, mem_rd, mem_wr;
  logic        mem_rw_byte;
  logic [31:0] addr, d_in;
  logic        mcu_busy, error, mcu_halt_req, mcu_halted, mcu_rst;
  logic [31:0] d_rd, pc, mcu_pc;
  logic [31:0] dbg_mem_addr, dbg_mem_din, mem_rdata;
  logic        dbg_mem_re, dbg_mem_we, mem_ack;
  logic [1:0]  dbg_mem_size;
  logic [4:0]  dbg_rf_addr;
  logic [31:0] dbg_rf_wd, rf_rdata;
  logic        dbg_rf_we;
  logic [2:0]  dbg_state;
  logic        dbg_paused;

  int n_vec = 0;
  int n_err = 0;

  mcu_debug_port #(.TIMEOUT(16), .RST_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .pause(pause),
    .resume(resume), .reset(rst_cmd), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rw_byte(mem_rw_byte),
    .addr(addr), .d_in(d_in), .mcu_busy(mcu_busy), .d_rd(d_rd),
    .error(error), .pc(pc), .mcu_halt_req(mcu_halt_req),
    .mcu_halted(mcu_halted), .mcu_rst(mcu_rst), .mcu_pc(mcu_pc),
    .dbg_mem_addr(dbg_mem_addr), .dbg_mem_din(dbg_mem_din),
    .dbg_mem_re(dbg_mem_re), .dbg_mem_we(dbg_mem_we),
    .dbg_mem_size(dbg_mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_rf_addr(dbg_rf_addr), .dbg_rf_wd(dbg_rf_wd), .dbg_rf_we(dbg_rf_we),
    .rf_rdata(rf_rdata), .dbg_state(dbg_state), .dbg_paused(dbg_paused)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- core model ----------------
  logic        halt_en = 1'b1;
  logic        ack_en  = 1'b1;
  int          halt_cnt;
  int          mem_cnt;
  logic [31:0] rf [32];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halt_cnt   <= 0;
      mcu_halted <= 1'b0;
    end else if (mcu_halt_req && halt_en) begin
      if (halt_cnt >= 4) mcu_halted <= 1'b1;
      else halt_cnt <= halt_cnt + 1;
    end else begin
      halt_cnt   <= 0;
      mcu_halted <= 1'b0;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_cnt <= 0;
    else if (dbg_mem_re || dbg_mem_we) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  assign mem_ack  = (dbg_mem_re || dbg_mem_we) && ack_en && (mem_cnt == 3);
  assign rf_rdata = (dbg_rf_addr == 5'd0) ? 32'h0000_0055 : rf[dbg_rf_addr];

  // free-running activity monitors; tests use before/after deltas
  int          rst_tot = 0, we_tot = 0, re_tot = 0, rf_we_tot = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [1:0]  wr_size = '0;

  always @(posedge clk) begin
    if (mcu_rst)    rst_tot <= rst_tot + 1;
    if (dbg_mem_we) we_tot  <= we_tot + 1;
    if (dbg_mem_re) re_tot  <= re_tot + 1;
    if (dbg_mem_we && mem_ack) begin
      wr_addr <= dbg_mem_addr;
      wr_data <= dbg_mem_din;
      wr_size <= dbg_mem_size;
    end
    if (dbg_rf_we) begin
      rf[dbg_rf_addr] <= dbg_rf_wd;
      rf_we_tot       <= rf_we_tot + 1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input logic [6:0] lines, input logic byt,
                           input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    valid = 1'b1;
    {pause, resume, rst_cmd, reg_rd, reg_wr, mem_rd, mem_wr} = lines;
    mem_rw_byte = byt;
    addr = a;
    d_in = d;
    @(posedge clk); #1;
    valid = 1'b0;
    {pause, resume, rst_cmd, reg_rd, reg_wr, mem_rd, mem_wr} = '0;
  endtask

  task automatic wait_idle(output int lat);
    lat = 0;
    while (mcu_busy && lat < 100) begin
      lat++;
      @(posedge clk); #1;
    end
    check("busy_bound", {31'd0, mcu_busy}, 32'd0);
  endtask

  task automatic run_cmd(input logic [6:0] lines, input logic byt,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat);
    start_cmd(lines, byt, a, d);
    wait_idle(lat);
  endtask

  // ---------------- stimulus ----------------
  int lat, r0, w0;

  initial begin
    reset_n = 1'b0;
    valid = 1'b0;
    {pause, resume, rst_cmd, reg_rd, reg_wr, mem_rd, mem_wr} = '0;
    mem_rw_byte = 1'b0;
    addr = '0;
    d_in = '0;
    mcu_pc = '0;
    mem_rdata = '0;
    #22 reset_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    check("rst_busy",  {31'd0, mcu_busy}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_d_rd",  d_rd, 32'd0);
    check("rst_halt",  {31'd0, mcu_halt_req}, 32'd0);
    check("rst_mrst",  {31'd0, mcu_rst}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_pause", {31'd0, dbg_paused}, 32'd0);

    // pc follows mcu_pc one cycle later
    mcu_pc = 32'hCAFE_0000;
    @(posedge clk); #1;
    check("pc_reg", pc, 32'hCAFE_0000);

    // pause, halted arrives 5 edges after the request
    run_cmd(L_PAU, 1'b0, 32'd0, 32'd0, lat);
    check("pause_err",    {31'd0, error}, 32'd0);
    check("pause_hreq",   {31'd0, mcu_halt_req}, 32'd1);
    check("pause_paused", {31'd0, dbg_paused}, 32'd1);

    // already paused: two busy cycles, no error
    run_cmd(L_PAU, 1'b0, 32'd0, 32'd0, lat);
    check("pause2_lat", lat, 32'd2);
    check("pause2_err", {31'd0, error}, 32'd0);

    // resume
    run_cmd(L_RES, 1'b0, 32'd0, 32'd0, lat);
    check("resume_lat",    lat, 32'd2);
    check("resume_hreq",   {31'd0, mcu_halt_req}, 32'd0);
    check("resume_paused", {31'd0, dbg_paused}, 32'd0);

    // memory read while running is refused
    r0 = re_tot;
    run_cmd(L_MRD, 1'b0, 32'h100, 32'd0, lat);
    check("unpaused_err", {31'd0, error}, 32'd1);
    check("unpaused_lat", lat, 32'd1);
    check("unpaused_re",  re_tot - r0, 32'd0);

    run_cmd(L_PAU, 1'b0, 32'd0, 32'd0, lat);
    check("pause_b_err", {31'd0, error}, 32'd0);

    // word write, ack on the 4th request cycle
    w0 = we_tot;
    run_cmd(L_MWR, 1'b0, 32'h100, 32'hDEAD_BEEF, lat);
    check("mwr_lat",   lat, 32'd5);
    check("mwr_we_n",  we_tot - w0, 32'd4);
    check("mwr_addr",  wr_addr, 32'h100);
    check("mwr_data",  wr_data, 32'hDEAD_BEEF);
    check("mwr_size",  {30'd0, wr_size}, 32'd2);
    check("mwr_err",   {31'd0, error}, 32'd0);
    check("mwr_we_lo", {31'd0, dbg_mem_we}, 32'd0);

    // word read, byte read lane 3
    mem_rdata = 32'hDEAD_BEEF;
    run_cmd(L_MRD, 1'b0, 32'h100, 32'd0, lat);
    check("mrd_word", d_rd, 32'hDEAD_BEEF);
    check("mrd_err",  {31'd0, error}, 32'd0);
    run_cmd(L_MRD, 1'b1, 32'h103, 32'd0, lat);
    check("mrd_byte3", d_rd, 32'h0000_00DE);
    run_cmd(L_MRD, 1'b1, 32'h101, 32'd0, lat);
    check("mrd_byte1", d_rd, 32'h0000_00BE);

    // byte write replicates the low byte
    run_cmd(L_MWR, 1'b1, 32'h101, 32'h1234_56A5, lat);
    check("bwr_data", wr_data, 32'hA5A5_A5A5);
    check("bwr_size", {30'd0, wr_size}, 32'd0);
    check("bwr_addr", wr_addr, 32'h101);

    // register file
    r0 = rf_we_tot;
    run_cmd(L_RWR, 1'b0, 32'd5, 32'h1234, lat);
    check("rwr_pulses", rf_we_tot - r0, 32'd1);
    check("rwr_lat",    lat, 32'd2);
    check("rwr_err",    {31'd0, error}, 32'd0);
    run_cmd(L_RRD, 1'b0, 32'd5, 32'd0, lat);
    check("rrd_x5", d_rd, 32'h1234);
    r0 = rf_we_tot;
    run_cmd(L_RWR, 1'b0, 32'd0, 32'hFFFF, lat);
    check("rwr_x0_we",  rf_we_tot - r0, 32'd0);
    check("rwr_x0_err", {31'd0, error}, 32'd0);
    run_cmd(L_RRD, 1'b0, 32'd0, 32'd0, lat);
    check("rrd_x0", d_rd, 32'd0);

    // accept-time errors
    r0 = re_tot;
    run_cmd(L_MRD, 1'b0, 32'h102, 32'd0, lat);
    check("misalign_err", {31'd0, error}, 32'd1);
    check("misalign_lat", lat, 32'd1);
    check("misalign_re",  re_tot - r0, 32'd0);
    run_cmd(L_RRD, 1'b0, 32'h20, 32'd0, lat);
    check("badidx_err", {31'd0, error}, 32'd1);
    run_cmd(L_RRD | L_MRD, 1'b0, 32'h4, 32'd0, lat);
    check("multi_err", {31'd0, error}, 32'd1);
    run_cmd(7'd0, 1'b0, 32'h0, 32'd0, lat);
    check("none_err", {31'd0, error}, 32'd1);

    // core reset while paused
    r0 = rst_tot;
    run_cmd(L_RST, 1'b0, 32'd0, 32'd0, lat);
    check("rst_cycles", rst_tot - r0, 32'd4);
    check("rst_lat",    lat, 32'd5);
    check("rst_hreq",   {31'd0, mcu_halt_req}, 32'd1);
    check("rst_err",    {31'd0, error}, 32'd0);

    // valid while busy is ignored (a resume here must not take effect)
    r0 = rst_tot;
    start_cmd(L_RST, 1'b0, 32'd0, 32'd0);
    valid = 1'b1; resume = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; resume = 1'b0;
    wait_idle(lat);
    check("ign_rst",    rst_tot - r0, 32'd4);
    check("ign_hreq",   {31'd0, mcu_halt_req}, 32'd1);
    check("ign_paused", {31'd0, dbg_paused}, 32'd1);
    check("ign_err",    {31'd0, error}, 32'd0);

    // memory timeout: preload d_rd with a good read first
    run_cmd(L_MRD, 1'b0, 32'h100, 32'd0, lat);
    check("pre_to_rd", d_rd, 32'hDEAD_BEEF);
    ack_en = 1'b0;
    run_cmd(L_MRD, 1'b0, 32'h100, 32'd0, lat);
    check("mto_lat", lat, 32'd17);
    check("mto_err", {31'd0, error}, 32'd1);
    check("mto_drd", d_rd, 32'd0);
    check("mto_re",  {31'd0, dbg_mem_re}, 32'd0);

    // asynchronous reset in the middle of MEM_WAIT
    start_cmd(L_MRD, 1'b0, 32'h200, 32'd0);
    @(posedge clk); #1;
    check("ar_pre_re", {31'd0, dbg_mem_re}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_re",    {31'd0, dbg_mem_re}, 32'd0);
    check("ar_addr",  dbg_mem_addr, 32'd0);
    check("ar_busy",  {31'd0, mcu_busy}, 32'd0);
    check("ar_hreq",  {31'd0, mcu_halt_req}, 32'd0);
    check("ar_pc",    pc, 32'd0);
    check("ar_state", {29'd0, dbg_state}, 32'd0);
    #10 reset_n = 1'b1;
    ack_en = 1'b1;
    @(posedge clk); #1;
    check("ar_idle",   {29'd0, dbg_state}, 32'd0);
    check("ar_paused", {31'd0, dbg_paused}, 32'd0);

    // halt timeout: core never reports halted
    halt_en = 1'b0;
    run_cmd(L_PAU, 1'b0, 32'd0, 32'd0, lat);
    check("hto_lat",    lat, 32'd17);
    check("hto_err",    {31'd0, error}, 32'd1);
    check("hto_hreq",   {31'd0, mcu_halt_req}, 32'd0);
    check("hto_paused", {31'd0, dbg_paused}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
